// File: rtl/noc_pkg.sv
// Shared NoC packet format {dest, src, data}: field geometry, state type and pack/unpack helpers.
package noc_pkg;
  localparam int DEST_W   = 3;
  localparam int DATA_W   = 8;
  localparam int PKT_W    = 2*DEST_W + DATA_W;
  localparam int DATA_LSB = 0;
  localparam int SRC_LSB  = DATA_LSB + DATA_W;
  localparam int DEST_LSB = SRC_LSB + DEST_W;

  typedef logic [DEST_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PKT_W-1:0]  pkt_t;

  typedef struct packed {
    addr_t dest;
    addr_t src;
    data_t data;
  } pkt_fields_t;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  function automatic pkt_t pkt_pack(input addr_t dest, input addr_t src, input data_t data);
    pkt_t p;
    p = '0;
    p[DEST_LSB +: DEST_W] = dest;
    p[SRC_LSB  +: DEST_W] = src;
    p[DATA_LSB +: DATA_W] = data;
    return p;
  endfunction

  function automatic pkt_fields_t pkt_unpack(input pkt_t p);
    pkt_fields_t f;
    f.dest = p[DEST_LSB +: DEST_W];
    f.src  = p[SRC_LSB  +: DEST_W];
    f.data = p[DATA_LSB +: DATA_W];
    return f;
  endfunction
endpackage

// File: rtl/ni_fifo.sv
// Power-of-two circular FIFO with wrap-bit pointers; exposes the head and the entry behind it
// so the consumer can reload its output register on every pop.
module ni_fifo #(
  parameter int  WIDTH = 14,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] head_nxt,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q, rd_nxt;

  assign rd_nxt   = rd_q + 1'b1;
  assign head     = mem_q[rd_q[AW-1:0]];
  assign head_nxt = mem_q[rd_nxt[AW-1:0]];
  assign count    = wr_q - rd_q;
  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full) wr_q <= wr_q + 1'b1;
      if (pop && !empty) rd_q <= rd_nxt;
    end
  end
endmodule

// File: rtl/node_ni.sv
// Leaf network interface: PE requests -> TX FIFO -> registered net_out stream, and
// net_in stream -> address filter -> 2-entry RX skid buffer -> PE delivery.
//   state   | meaning
//   TX_IDLE | nothing presented on net_out
//   TX_SEND | FIFO head held on net_out_packet with net_out_valid high
module node_ni
  import noc_pkg::*;
#(
  parameter int                    WIDTH_packet = PKT_W,
  parameter int                    WIDTH_dest   = DEST_W,
  parameter int                    WIDTH_data   = DATA_W,
  parameter logic [WIDTH_dest-1:0] NODE_ADDR    = '0,
  parameter int                    TX_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pe_tx_valid,
  output logic                    pe_tx_ready,
  input  logic [WIDTH_dest-1:0]   pe_tx_dest,
  input  logic [WIDTH_data-1:0]   pe_tx_data,
  output logic                    net_out_valid,
  input  logic                    net_out_ready,
  output logic [WIDTH_packet-1:0] net_out_packet,
  input  logic                    net_in_valid,
  output logic                    net_in_ready,
  input  logic [WIDTH_packet-1:0] net_in_packet,
  output logic                    pe_rx_valid,
  input  logic                    pe_rx_ready,
  output logic [WIDTH_dest-1:0]   pe_rx_src,
  output logic [WIDTH_data-1:0]   pe_rx_data,
  output logic                    err_self,
  output logic                    err_misroute
);
  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam int EW = WIDTH_dest + WIDTH_data;

  tx_state_e               state_q;
  logic                    tx_ready_q, err_self_q, out_valid_q;
  logic [WIDTH_packet-1:0] out_pkt_q, tx_pkt, fifo_head, fifo_head_nxt;
  logic                    tx_fire, tx_self, tx_push, out_fire, fifo_empty, fifo_full;
  logic [CW-1:0]           fifo_count, tx_cnt_nxt;

  assign tx_fire    = pe_tx_valid && tx_ready_q;
  assign tx_self    = (pe_tx_dest == NODE_ADDR);
  assign tx_push    = tx_fire && !tx_self && !fifo_full;
  assign out_fire   = out_valid_q && net_out_ready;
  assign tx_pkt     = pkt_pack(pe_tx_dest, NODE_ADDR, pe_tx_data);
  assign tx_cnt_nxt = fifo_count + CW'(tx_push) - CW'(out_fire);

  ni_fifo #(.WIDTH(WIDTH_packet), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tx_push),
    .wdata    (tx_pkt),
    .pop      (out_fire),
    .head     (fifo_head),
    .head_nxt (fifo_head_nxt),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // On a pop the output register reloads with the next head; with one entry left that is
  // the word being pushed this very cycle, so it comes straight from the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TX_IDLE;
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
      tx_ready_q  <= 1'b0;
      err_self_q  <= 1'b0;
    end else begin
      tx_ready_q <= (tx_cnt_nxt < CW'(TX_DEPTH));
      err_self_q <= tx_fire && tx_self;
      case (state_q)
        TX_IDLE: begin
          if (!fifo_empty) begin
            state_q     <= TX_SEND;
            out_valid_q <= 1'b1;
            out_pkt_q   <= fifo_head;
          end
        end
        TX_SEND: begin
          if (out_fire) begin
            if (fifo_count == CW'(1) && !tx_push) begin
              state_q     <= TX_IDLE;
              out_valid_q <= 1'b0;
              out_pkt_q   <= '0;
            end else if (fifo_count == CW'(1)) begin
              out_pkt_q <= tx_pkt;
            end else begin
              out_pkt_q <= fifo_head_nxt;
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign pe_tx_ready    = tx_ready_q;
  assign net_out_valid  = out_valid_q;
  assign net_out_packet = out_pkt_q;
  assign err_self       = err_self_q;

  logic [1:0]    rx_cnt_q, rx_cnt_d;
  logic [EW-1:0] slot0_q, slot0_d, slot1_q, slot1_d, rx_entry;
  logic          in_ready_q, err_mis_q, rx_in_fire, rx_enq, rx_deq;
  pkt_fields_t   in_fields;

  assign in_fields  = pkt_unpack(net_in_packet);
  assign rx_in_fire = net_in_valid && in_ready_q;
  assign rx_enq     = rx_in_fire && (in_fields.dest == NODE_ADDR);
  assign rx_deq     = (rx_cnt_q != 2'd0) && pe_rx_ready;
  assign rx_entry   = {in_fields.src, in_fields.data};

  // slot0 is always the oldest entry
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    case ({rx_enq, rx_deq})
      2'b01: begin
        slot0_d  = slot1_q;
        rx_cnt_d = rx_cnt_q - 2'd1;
      end
      2'b10: begin
        if (rx_cnt_q == 2'd0) slot0_d = rx_entry;
        else                  slot1_d = rx_entry;
        rx_cnt_d = rx_cnt_q + 2'd1;
      end
      2'b11: begin
        if (rx_cnt_q == 2'd1) begin
          slot0_d = rx_entry;
        end else begin
          slot0_d = slot1_q;
          slot1_d = rx_entry;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_q   <= 2'd0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      in_ready_q <= 1'b0;
      err_mis_q  <= 1'b0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      in_ready_q <= (rx_cnt_d != 2'd2);
      err_mis_q  <= rx_in_fire && (in_fields.dest != NODE_ADDR);
    end
  end

  assign net_in_ready            = in_ready_q;
  assign pe_rx_valid             = (rx_cnt_q != 2'd0);
  assign {pe_rx_src, pe_rx_data} = slot0_q;
  assign err_misroute            = err_mis_q;
endmodule

// File: tb/tb_node_ni.sv
// Directed scenarios followed by randomized traffic checked against a queue-level model of node_ni.
module tb_node_ni;
  localparam logic [2:0] NODE = 3'b000;

  logic        clk, rst;
  logic        pe_tx_valid, pe_tx_ready;
  logic [2:0]  pe_tx_dest;
  logic [7:0]  pe_tx_data;
  logic        net_out_valid, net_out_ready;
  logic [13:0] net_out_packet;
  logic        net_in_valid, net_in_ready;
  logic [13:0] net_in_packet;
  logic        pe_rx_valid, pe_rx_ready;
  logic [2:0]  pe_rx_src;
  logic [7:0]  pe_rx_data;
  logic        err_self, err_misroute;

  int n_tests = 0;
  int n_fail  = 0;

  logic [13:0] tx_q[$];
  logic [10:0] rx_q[$];
  logic        tx_f, out_f, in_f, rx_f, exp_self, exp_mis;
  int          prev_size;

  node_ni #(
    .WIDTH_packet(14), .WIDTH_dest(3), .WIDTH_data(8), .NODE_ADDR(NODE), .TX_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .pe_tx_valid(pe_tx_valid), .pe_tx_ready(pe_tx_ready),
    .pe_tx_dest(pe_tx_dest), .pe_tx_data(pe_tx_data),
    .net_out_valid(net_out_valid), .net_out_ready(net_out_ready),
    .net_out_packet(net_out_packet),
    .net_in_valid(net_in_valid), .net_in_ready(net_in_ready),
    .net_in_packet(net_in_packet),
    .pe_rx_valid(pe_rx_valid), .pe_rx_ready(pe_rx_ready),
    .pe_rx_src(pe_rx_src), .pe_rx_data(pe_rx_data),
    .err_self(err_self), .err_misroute(err_misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pe_tx_valid = 1'b0; pe_tx_dest = '0; pe_tx_data = '0;
    net_out_ready = 1'b0; net_in_valid = 1'b0; net_in_packet = '0; pe_rx_ready = 1'b0;
    tick(); tick();
    chk("rst_tx_ready", pe_tx_ready, 0);
    chk("rst_in_ready", net_in_ready, 0);
    chk("rst_out_valid", net_out_valid, 0);
    chk("rst_out_pkt", net_out_packet, 0);
    chk("rst_rx_valid", pe_rx_valid, 0);
    chk("rst_err_self", err_self, 0);
    chk("rst_err_mis", err_misroute, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_tx_ready", pe_tx_ready, 1);
    chk("post_rst_in_ready", net_in_ready, 1);

    // single send with output held off for a while
    pe_tx_valid = 1'b1; pe_tx_dest = 3'd5; pe_tx_data = 8'hA7;
    tick();
    pe_tx_valid = 1'b0;
    chk("send_lat1_valid", net_out_valid, 0);
    tick();
    chk("send_valid", net_out_valid, 1);
    chk("send_pkt", net_out_packet, 14'b101_000_10100111);
    tick(); tick();
    chk("send_hold_valid", net_out_valid, 1);
    chk("send_hold_pkt", net_out_packet, 14'b101_000_10100111);
    net_out_ready = 1'b1;
    tick();
    net_out_ready = 1'b0;
    chk("send_done_valid", net_out_valid, 0);

    // backpressure: fill 4, fifth refused, then drain in order at full rate
    for (int i = 0; i < 4; i++) begin
      pe_tx_valid = 1'b1; pe_tx_dest = 3'(i + 1); pe_tx_data = 8'(8'h10 + i);
      chk("bp_accept_ready", pe_tx_ready, 1);
      tick();
    end
    pe_tx_dest = 3'd6; pe_tx_data = 8'h99;
    chk("bp_full_ready", pe_tx_ready, 0);
    pe_tx_valid = 1'b0;
    net_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_valid", net_out_valid, 1);
      chk("bp_out_pkt", net_out_packet, {3'(i + 1), NODE, 8'(8'h10 + i)});
      tick();
    end
    chk("bp_drained", net_out_valid, 0);
    chk("bp_ready_back", pe_tx_ready, 1);
    net_out_ready = 1'b0;

    // self-send
    pe_tx_valid = 1'b1; pe_tx_dest = NODE; pe_tx_data = 8'h55;
    chk("self_ready", pe_tx_ready, 1);
    tick();
    pe_tx_valid = 1'b0;
    chk("self_err", err_self, 1);
    chk("self_no_out", net_out_valid, 0);
    tick();
    chk("self_err_once", err_self, 0);
    chk("self_no_out2", net_out_valid, 0);
    tick();
    chk("self_no_out3", net_out_valid, 0);

    // receive into skid buffer with PE stalled, then drain with concurrent enqueue
    net_in_valid = 1'b1; net_in_packet = 14'b000_011_00010001;
    chk("rx_ready0", net_in_ready, 1);
    tick();
    chk("rx_valid1", pe_rx_valid, 1);
    chk("rx_ready1", net_in_ready, 1);
    tick();
    chk("rx_full_ready", net_in_ready, 0);
    net_in_packet = 14'b000_011_00110011;
    tick();
    chk("rx_still_full", net_in_ready, 0);
    chk("rx_head_src", pe_rx_src, 3);
    chk("rx_head_data", pe_rx_data, 8'h11);
    pe_rx_ready = 1'b1;
    tick();
    chk("rx_second_data", pe_rx_data, 8'h11);
    chk("rx_slot_free", net_in_ready, 1);
    tick();
    net_in_valid = 1'b0;
    chk("rx_enq_deq_valid", pe_rx_valid, 1);
    chk("rx_third_data", pe_rx_data, 8'h33);
    chk("rx_third_src", pe_rx_src, 3);
    tick();
    chk("rx_empty", pe_rx_valid, 0);
    pe_rx_ready = 1'b0;

    // misroute
    net_in_valid = 1'b1; net_in_packet = {3'd6, 3'd2, 8'h5A};
    chk("mis_ready", net_in_ready, 1);
    tick();
    net_in_valid = 1'b0;
    chk("mis_err", err_misroute, 1);
    chk("mis_no_rx", pe_rx_valid, 0);
    tick();
    chk("mis_err_once", err_misroute, 0);
    chk("mis_no_rx2", pe_rx_valid, 0);

    // reset in the middle of a queued burst
    for (int i = 0; i < 3; i++) begin
      pe_tx_valid = 1'b1; pe_tx_dest = 3'(i + 2); pe_tx_data = 8'(8'hC0 + i);
      net_in_valid = (i == 0); net_in_packet = {NODE, 3'd1, 8'h77};
      tick();
    end
    pe_tx_valid = 1'b0; net_in_valid = 1'b0;
    chk("mid_burst_valid", net_out_valid, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx_ready", pe_tx_ready, 0);
    chk("mid_rst_in_ready", net_in_ready, 0);
    chk("mid_rst_out_valid", net_out_valid, 0);
    chk("mid_rst_out_pkt", net_out_packet, 0);
    chk("mid_rst_rx_valid", pe_rx_valid, 0);
    chk("mid_rst_errs", {err_self, err_misroute}, 0);
    rst = 1'b0; net_out_ready = 1'b1; pe_rx_ready = 1'b1;
    tick();
    chk("mid_post_tx_ready", pe_tx_ready, 1);
    chk("mid_post_in_ready", net_in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      chk("mid_no_stale_out", net_out_valid, 0);
      chk("mid_no_stale_rx", pe_rx_valid, 0);
      tick();
    end

    // randomized traffic against the queue model
    tx_f = 1'b0; out_f = 1'b0; in_f = 1'b0; rx_f = 1'b0; prev_size = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (!pe_tx_valid || tx_f) begin
        pe_tx_valid = ($urandom_range(0, 3) != 0);
        pe_tx_dest  = 3'($urandom_range(0, 7));
        pe_tx_data  = 8'($urandom);
      end
      if (!net_in_valid || in_f) begin
        net_in_valid  = ($urandom_range(0, 2) != 0);
        net_in_packet = {(($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : NODE),
                         3'($urandom_range(0, 7)), 8'($urandom)};
      end
      net_out_ready = (cyc < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      pe_rx_ready   = 1'($urandom_range(0, 1));

      chk("rnd_tx_ready", pe_tx_ready, tx_q.size() < 4);
      chk("rnd_in_ready", net_in_ready, rx_q.size() < 2);
      chk("rnd_rx_valid", pe_rx_valid, rx_q.size() != 0);
      if (rx_q.size() != 0) chk("rnd_rx_entry", {pe_rx_src, pe_rx_data}, rx_q[0]);
      chk("rnd_out_valid", net_out_valid, (tx_q.size() != 0) && (prev_size != 0));
      if (net_out_valid && tx_q.size() != 0) chk("rnd_out_pkt", net_out_packet, tx_q[0]);

      tx_f     = pe_tx_valid && pe_tx_ready;
      out_f    = net_out_valid && net_out_ready;
      in_f     = net_in_valid && net_in_ready;
      rx_f     = pe_rx_valid && pe_rx_ready;
      exp_self = tx_f && (pe_tx_dest == NODE);
      exp_mis  = in_f && (net_in_packet[13:11] != NODE);
      prev_size = tx_q.size();
      if (out_f && tx_q.size() != 0) void'(tx_q.pop_front());
      if (tx_f && !exp_self) tx_q.push_back({pe_tx_dest, NODE, pe_tx_data});
      if (rx_f && rx_q.size() != 0) void'(rx_q.pop_front());
      if (in_f && !exp_mis) rx_q.push_back(net_in_packet[10:0]);
      tick();
      chk("rnd_err_self", err_self, exp_self);
      chk("rnd_err_mis", err_misroute, exp_mis);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
